// File: rtl/scan_chain_reg.sv
// Multi-chain muxed-D scan register: capture, per-segment serial shift, hold, shift counter with DONE.
// Optional SCAN_UPDATE_EN adds a UPD-loaded shadow register that drives Q.
module scan_chain_reg #(
    parameter int unsigned      WIDTH   = 8,
    parameter int unsigned      CHAINS  = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int unsigned     LEN     = WIDTH / CHAINS,
    localparam int unsigned     CW      = (LEN > 1) ? $clog2(LEN) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [WIDTH-1:0]  D,
    input  logic              EN,
    input  logic [CHAINS-1:0] SI,
    input  logic              HOLD,
`ifdef SCAN_UPDATE_EN
    input  logic              UPD,
`endif
    output logic [WIDTH-1:0]  Q,
    output logic [CHAINS-1:0] SO,
    output logic [CW-1:0]     CNT,
    output logic              DONE
);

    logic [WIDTH-1:0] reg_q, reg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] shift_val;
    logic [WIDTH-1:0] shr;

    assign shr = reg_q >> 1;

    // Each segment MSB takes its own SI bit; every other bit takes its upper neighbour.
    always_comb begin
        shift_val = shr;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if ((i % LEN) == (LEN - 1)) begin
                shift_val[i] = SI[i / LEN];
            end
        end
    end

    always_comb begin
        reg_d  = reg_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (!HOLD) begin
            if (EN) begin
                reg_d = shift_val;
                if (cnt_q == CW'(LEN - 1)) begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else begin
                reg_d = D;
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            reg_q  <= RST_VAL;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            reg_q  <= reg_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    for (genvar c = 0; c < CHAINS; c++) begin : g_so
        assign SO[c] = reg_q[c * LEN];
    end

    assign CNT  = cnt_q;
    assign DONE = done_q;

`ifdef SCAN_UPDATE_EN
    logic [WIDTH-1:0] shadow_q, shadow_d;

    // Shadow takes the pre-edge register, so a same-edge shift waits for the next UPD.
    always_comb begin
        shadow_d = shadow_q;
        if (UPD && !HOLD) begin
            shadow_d = reg_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            shadow_q <= RST_VAL;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign Q = shadow_q;
`else
    assign Q = reg_q;
`endif

endmodule
